// File: rtl/out_io_arbiter.sv
// Round-robin arbiter that serializes one requester's word at a time onto a registered
// output pad line as a framed bitstream (start 0, data LSB first, stop 1, idle high).
module out_io_arbiter #(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 8,
   parameter  int DIV   = 1,
   localparam int OW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                    IQC,
   input  logic                    QRT,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   data,
   output logic [NREQ-1:0]         ack,
   output logic                    busy,
   output logic [OW-1:0]           owner,
   output logic                    OQI
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [7:0]          r_div;
   logic [7:0]          w_div_nxt;
   logic [BW-1:0]       r_bit;
   logic [BW-1:0]       w_bit_nxt;
   logic [WIDTH-1:0]    r_shift;
   logic [WIDTH-1:0]    w_shift_nxt;
   logic [OW-1:0]       r_ptr;
   logic [OW-1:0]       w_ptr_nxt;
   logic [OW-1:0]       r_owner;
   logic [OW-1:0]       w_owner_nxt;
   logic [NREQ-1:0]     r_ack;
   logic [NREQ-1:0]     w_ack_nxt;
   logic                r_busy;
   logic                w_busy_nxt;
   logic                r_oqi;
   logic                w_oqi_nxt;

   logic                w_div_tc;
   logic                w_decide;
   logic                w_any;
   logic                w_grant;
   logic [NREQ-1:0]     w_rot;
   logic [NREQ-1:0]     w_gnt_oh;
   logic [OW-1:0]       w_gnt;
   int                  w_off;
   int                  w_sum;

   assign w_div_tc = (r_div == DIV_LAST);
   assign w_decide = (r_state == S_IDLE) || ((r_state == S_STOP) && w_div_tc);
   assign w_grant  = w_decide && w_any;

   // Rotate the requests so the slot right after the pointer sits at bit 0, take the
   // lowest set bit, then map the offset back to an absolute requester index.
   always_comb begin
      w_rot = NREQ'({req, req} >> (int'(r_ptr) + 1));
      w_any = |w_rot;
      w_off = 0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (w_rot[j]) w_off = j;
      end
      w_sum = int'(r_ptr) + 1 + w_off;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_gnt    = OW'(w_sum);
      w_gnt_oh = '0;
      w_gnt_oh[w_gnt] = 1'b1;
   end

   // State register
   always_ff @(posedge IQC or posedge QRT) begin
      if (QRT) begin
         r_state <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: defaulting to the current state up front keeps this block free of inferred latches.
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_any) w_state_nxt = S_START;
         S_START: if (w_div_tc) w_state_nxt = S_DATA;
         S_DATA:  if (w_div_tc && (r_bit == BIT_LAST)) w_state_nxt = S_STOP;
         S_STOP:  if (w_div_tc) w_state_nxt = w_any ? S_START : S_IDLE;
      endcase
   end

   // Output / datapath next values; OQI is computed for the state being entered so the
   // pad register shows the new bit in the same cycle the state changes.
   always_comb begin
      w_div_nxt   = (w_div_tc || (r_state == S_IDLE)) ? 8'd0 : (r_div + 8'd1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_ack_nxt   = '0;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;

      if ((r_state == S_DATA) && w_div_tc) begin
         w_bit_nxt   = (r_bit == BIT_LAST) ? '0 : (r_bit + BW'(1));
         w_shift_nxt = r_shift >> 1;
      end

      if (w_grant) begin
         w_shift_nxt = data[int'(w_gnt)*WIDTH +: WIDTH];
         w_bit_nxt   = '0;
         w_ack_nxt   = w_gnt_oh;
         w_owner_nxt = w_gnt;
         w_ptr_nxt   = w_gnt;
      end

      w_busy_nxt = (w_state_nxt != S_IDLE);
      unique case (w_state_nxt)
         S_START: w_oqi_nxt = 1'b0;
         S_DATA:  w_oqi_nxt = w_shift_nxt[0];
         default: w_oqi_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge IQC or posedge QRT) begin
      if (QRT) begin
         r_div   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_ptr   <= OW'(NREQ - 1);
         r_owner <= '0;
         r_ack   <= '0;
         r_busy  <= 1'b0;
         r_oqi   <= 1'b1;
      end else begin
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_ack   <= w_ack_nxt;
         r_busy  <= w_busy_nxt;
         r_oqi   <= w_oqi_nxt;
      end
   end

   assign ack   = r_ack;
   assign busy  = r_busy;
   assign owner = r_owner;
   assign OQI   = r_oqi;

endmodule

// File: tb/tb_out_io_arbiter.sv
// Bench for out_io_arbiter: two instances (DIV=1 and DIV=3) checked every cycle against a
// frame-level reference model, plus directed literal checks and a randomized phase.
module tb_out_io_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int OW    = 2;
   localparam int FBITS = WIDTH + 2;

   logic                  clk;
   logic                  qrt;
   logic [NREQ-1:0]       req_a  [2];
   logic [NREQ*WIDTH-1:0] data_a [2];
   logic [NREQ-1:0]       keep   [2];
   wire  [NREQ-1:0]       ack_a  [2];
   wire                   busy_a [2];
   wire  [OW-1:0]         owner_a[2];
   wire                   oqi_a  [2];

   int n_tests = 0;
   int n_fail  = 0;
   logic ack2_seen;

   out_io_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DIV(1)) u_dut_d1 (
      .IQC(clk), .QRT(qrt), .req(req_a[0]), .data(data_a[0]),
      .ack(ack_a[0]), .busy(busy_a[0]), .owner(owner_a[0]), .OQI(oqi_a[0])
   );

   out_io_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DIV(3)) u_dut_d3 (
      .IQC(clk), .QRT(qrt), .req(req_a[1]), .data(data_a[1]),
      .ack(ack_a[1]), .busy(busy_a[1]), .owner(owner_a[1]), .OQI(oqi_a[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int div_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic int oh_idx(input logic [NREQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NREQ; i++) if (v[i] && r < 0) r = i;
      return r;
   endfunction

   // Reference model: a frame is a (WIDTH+2)-bit vector; during frame cycle t the line
   // carries bit t/DIV. A new grant is decided whenever no frame remains.
   logic             m_active [2] = '{1'b0, 1'b0};
   int               m_t      [2] = '{0, 0};
   logic [FBITS-1:0] m_frame  [2] = '{'0, '0};
   int               m_ptr    [2] = '{NREQ - 1, NREQ - 1};
   int               m_owner  [2] = '{0, 0};
   logic [NREQ-1:0]  m_ack    [2] = '{'0, '0};

   always @(posedge clk or posedge qrt) begin
      int g;
      for (int k = 0; k < 2; k++) begin
         if (qrt) begin
            m_active[k] = 1'b0;
            m_t[k]      = 0;
            m_ptr[k]    = NREQ - 1;
            m_owner[k]  = 0;
            m_ack[k]    = '0;
         end else begin
            m_ack[k] = '0;
            if (m_active[k]) begin
               m_t[k]++;
               if (m_t[k] == FBITS * div_of(k)) m_active[k] = 1'b0;
            end
            if (!m_active[k]) begin
               for (int s = 1; s <= NREQ; s++) begin
                  g = (m_ptr[k] + s) % NREQ;
                  if (!m_active[k] && req_a[k][g]) begin
                     m_active[k] = 1'b1;
                     m_t[k]      = 0;
                     m_frame[k]  = {1'b1, data_a[k][g*WIDTH +: WIDTH], 1'b0};
                     m_ptr[k]    = g;
                     m_owner[k]  = g;
                     m_ack[k][g] = 1'b1;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         check(k == 0 ? "oqi_d1" : "oqi_d3", 32'(oqi_a[k]),
               32'(m_active[k] ? m_frame[k][m_t[k] / div_of(k)] : 1'b1));
         check(k == 0 ? "ack_d1" : "ack_d3", 32'(ack_a[k]), 32'(m_ack[k]));
         check(k == 0 ? "busy_d1" : "busy_d3", 32'(busy_a[k]), 32'(m_active[k]));
         if (m_active[k])
            check(k == 0 ? "owner_d1" : "owner_d3", 32'(owner_a[k]), 32'(m_owner[k]));
      end
   end

   // One cycle: advance to the falling edge, then let each requester react to its ack.
   task automatic step();
      @(negedge clk);
      if (ack_a[0][2] === 1'b1) ack2_seen = 1'b1;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (ack_a[k][i] === 1'b1) begin
               if (keep[k][i]) data_a[k][i*WIDTH +: WIDTH] = WIDTH'($urandom);
               else            req_a[k][i] = 1'b0;
            end
         end
      end
   endtask

   task automatic wait_ack(input int k, input int i, input int budget);
      int c = 0;
      do begin
         step();
         c++;
      end while (ack_a[k][i] !== 1'b1 && c < budget);
      check("wait_ack", 32'(ack_a[k][i]), 32'd1);
   endtask

   task automatic wait_idle(input int k, input int budget);
      int c = 0;
      while ((busy_a[k] !== 1'b0 || req_a[k] != '0) && c < budget) begin
         step();
         c++;
      end
      check("wait_idle", 32'(busy_a[k]), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_oqi"},   32'(oqi_a[0]),   32'd1);
      check({tag, "_ack"},   32'(ack_a[0]),   32'd0);
      check({tag, "_busy"},  32'(busy_a[0]),  32'd0);
      check({tag, "_owner"}, 32'(owner_a[0]), 32'd0);
   endtask

   int               ack_at  [4];
   logic [NREQ-1:0]  ack_vec [4];
   int               ack_own [4];
   int               log_idx [6];
   int               exp_fair[6] = '{0, 2, 0, 1, 2, 0};
   logic [FBITS-1:0] trace;
   logic [FBITS-1:0] exp_a5 = 10'b11_0100_1010;
   logic [FBITS-1:0] exp_3c = 10'b10_0111_1000;
   logic [29:0]      trace30;
   int               n_ack;
   int               busy_cnt;

   initial begin
      qrt = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req_a[k]  = '0;
         data_a[k] = '0;
         keep[k]   = '0;
      end
      ack2_seen = 1'b0;
      for (int n = 0; n < 4; n++) begin
         ack_at[n] = 0; ack_vec[n] = '0; ack_own[n] = 0;
      end

      // Reset with every requester asking: outputs go to idle values with no clock edge.
      #1 qrt = 1'b1;
      req_a[0]  = 4'hF;
      data_a[0] = {8'h44, 8'h33, 8'h22, 8'h11};
      #1 check_reset_outputs("rst_imm");
      @(negedge clk);
      check_reset_outputs("rst_hold");
      qrt = 1'b0;
      #1 check_reset_outputs("rst_rel");

      // All four at once: grants 0..3, ack pulses 10 cycles apart, 40 busy cycles.
      n_ack = 0;
      busy_cnt = 0;
      for (int c = 0; c < 45; c++) begin
         step();
         if (busy_a[0] === 1'b1) busy_cnt++;
         if (ack_a[0] != '0 && n_ack < 4) begin
            ack_at[n_ack]  = c;
            ack_vec[n_ack] = ack_a[0];
            ack_own[n_ack] = int'(owner_a[0]);
            n_ack++;
         end
      end
      check("all4_ack_count", 32'(n_ack), 32'd4);
      check("all4_busy_cycles", 32'(busy_cnt), 32'd40);
      for (int n = 0; n < 4; n++) begin
         check("all4_grant", 32'(ack_vec[n]), 32'(1 << n));
         check("all4_owner", 32'(ack_own[n]), 32'(n));
         if (n > 0) check("all4_ack_spacing", 32'(ack_at[n] - ack_at[n-1]), 32'd10);
      end

      // Fairness: 0 and 2 held, 1 joins mid-stream after the second grant of 0.
      keep[0][0] = 1'b1;
      keep[0][2] = 1'b1;
      data_a[0][0*WIDTH +: WIDTH] = 8'h5A;
      data_a[0][2*WIDTH +: WIDTH] = 8'hC3;
      req_a[0] = 4'b0101;
      n_ack = 0;
      for (int c = 0; c < 100 && n_ack < 6; c++) begin
         step();
         if (ack_a[0] != '0) begin
            log_idx[n_ack] = oh_idx(ack_a[0]);
            check("fair_owner", 32'(owner_a[0]), 32'(log_idx[n_ack]));
            n_ack++;
            if (n_ack == 3) begin
               data_a[0][1*WIDTH +: WIDTH] = 8'h96;
               req_a[0][1] = 1'b1;
            end
         end
      end
      check("fair_ack_count", 32'(n_ack), 32'd6);
      for (int n = 0; n < 6; n++) check("fair_order", 32'(log_idx[n]), 32'(exp_fair[n]));
      keep[0]  = '0;
      req_a[0] = '0;
      wait_idle(0, 40);

      // Single frame 8'hA5 from requester 0.
      data_a[0][7:0] = 8'hA5;
      req_a[0] = 4'b0001;
      wait_ack(0, 0, 5);
      for (int b = 0; b < FBITS; b++) begin
         if (b > 0) step();
         trace[b] = oqi_a[0];
         if (b == 0) check("single_ack_pulse", 32'(ack_a[0]), 32'h1);
         if (b == 1) check("single_ack_width", 32'(ack_a[0]), 32'h0);
      end
      check("single_frame_bits", 32'(trace), 32'(exp_a5));
      step();
      check("single_end_busy", 32'(busy_a[0]), 32'd0);
      check("single_end_oqi", 32'(oqi_a[0]), 32'd1);

      // Reset during DATA bit 4 of requester 2 while requester 1 waits.
      data_a[0][2*WIDTH +: WIDTH] = 8'h68;
      req_a[0] = 4'b0100;
      wait_ack(0, 2, 5);
      data_a[0][1*WIDTH +: WIDTH] = 8'h3C;
      req_a[0][1] = 1'b1;
      repeat (5) step();
      check("mid_bit4_oqi", 32'(oqi_a[0]), 32'd0);
      check("mid_bit4_owner", 32'(owner_a[0]), 32'd2);
      #1 qrt = 1'b1;
      ack2_seen = 1'b0;
      #1 check_reset_outputs("mid_rst_imm");
      @(posedge clk);
      #1 check_reset_outputs("mid_rst_hold");
      @(negedge clk);
      qrt = 1'b0;
      #1 check_reset_outputs("mid_rst_rel");
      wait_ack(0, 1, 5);
      check("mid_regrant_vec", 32'(ack_a[0]), 32'h2);
      check("mid_regrant_owner", 32'(owner_a[0]), 32'd1);
      for (int b = 0; b < FBITS; b++) begin
         if (b > 0) step();
         trace[b] = oqi_a[0];
      end
      check("mid_req1_frame", 32'(trace), 32'(exp_3c));
      wait_idle(0, 20);
      check("mid_no_reack2", 32'(ack2_seen), 32'd0);

      // Divider instance: 8'h01 with DIV=3 gives 0x3, 1x3, 0x21, 1x3.
      data_a[1][7:0] = 8'h01;
      req_a[1] = 4'b0001;
      wait_ack(1, 0, 5);
      for (int c = 0; c < 30; c++) begin
         if (c > 0) step();
         trace30[c] = oqi_a[1];
         if (c == 29) check("div_busy_last", 32'(busy_a[1]), 32'd1);
      end
      check("div_frame_bits", 32'(trace30), 32'h3800_0038);
      step();
      check("div_end_busy", 32'(busy_a[1]), 32'd0);
      check("div_end_oqi", 32'(oqi_a[1]), 32'd1);

      // Randomized traffic on both instances; the per-cycle model compare does the checking.
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NREQ; i++) begin
               if (!req_a[k][i] && $urandom_range(0, 5) == 0) begin
                  data_a[k][i*WIDTH +: WIDTH] = WIDTH'($urandom);
                  keep[k][i]  = ($urandom_range(0, 3) == 0);
                  req_a[k][i] = 1'b1;
               end
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         keep[k]  = '0;
         req_a[k] = '0;
      end
      wait_idle(0, 40);
      wait_idle(1, 100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
